// File: rtl/seg_pkg.sv
// Shared types, constants and the leading-zero helper for the 7-segment scan controller.
package seg_pkg;

  localparam int MAX_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [3:0] nibble_t;

  // Bit k set when digit k should be suppressed: nibbles k..n-1 all zero, digit 0 never.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] display,
                                                    input int n);
    logic    zero_above;
    nibble_t nib;
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
      if (k < n) begin
        nib        = display[4*k +: 4];
        zero_above = zero_above && (nib == 4'h0);
        if (k != 0) lz_mask[k] = zero_above;
      end
    end
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low 7-segment pattern, segment order {g,f,e,d,c,b,a}.
module hex7seg
  import seg_pkg::*;
(
  input  nibble_t    nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of a common-anode 7-segment bank with a double-buffered,
// tear-free load handshake and a blanking gap at the start of every digit slot.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic                    lz_suppress_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]             count_q, count_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   disp_val_q, pend_val_q;
  logic [NUM_DIGITS-1:0]     disp_dp_q, pend_dp_q;
  logic                      pend_full_q;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic                      frame_q;

  logic                      tick, wrap, accept;
  nibble_t                   cur_nib;
  logic [6:0]                hex_seg;
  logic [4*MAX_DIGITS-1:0]   disp_ext;
  logic [MAX_DIGITS-1:0]     lz_vec;

  assign tick         = (count_q == CNT_LAST);
  assign wrap         = tick && (idx_q == IDX_LAST);
  assign accept       = load_valid_i && !pend_full_q;
  assign load_ready_o = !pend_full_q;

  assign count_d = tick ? '0 : count_q + 1'b1;
  assign idx_d   = !tick ? idx_q : (wrap ? '0 : idx_q + 1'b1);

  assign cur_nib  = disp_val_q[4*int'(idx_q) +: 4];
  assign disp_ext = (4*MAX_DIGITS)'(disp_val_q);
  assign lz_vec   = lz_mask(disp_ext, NUM_DIGITS);

  hex7seg u_hex7seg (
    .nibble_i (cur_nib),
    .seg_o    (hex_seg)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = '1;
    if (count_q >= CNT_BLANK) begin
      an_d[idx_q] = 1'b0;
      dp_d        = !disp_dp_q[idx_q];
      seg_d       = (lz_suppress_i && lz_vec[idx_q]) ? SEG_BLANK : hex_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      idx_q       <= '0;
      disp_val_q  <= '0;
      disp_dp_q   <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      an_q        <= '1;
      frame_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      frame_q <= wrap;
      // accept needs an empty buffer and the copy needs a full one, so they never collide
      if (accept) begin
        pend_val_q  <= value_i;
        pend_dp_q   <= dp_i;
        pend_full_q <= 1'b1;
      end else if (wrap && pend_full_q) begin
        disp_val_q  <= pend_val_q;
        disp_dp_q   <= pend_dp_q;
        pend_full_q <= 1'b0;
      end
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected digit slots are queued per frame and
// compared by an independent monitor at the start of every active slot.
module tb_seg_scan_ctrl;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [4*N-1:0] value_i = '0;
  logic [N-1:0]   dp_i = '0;
  logic           load_valid_i = 1'b0;
  logic           load_ready_o;
  logic           lz_suppress_i = 1'b0;
  logic [6:0]     seg_o;
  logic           dp_o;
  logic [N-1:0]   an_o;
  logic           frame_o;

  seg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .value_i       (value_i),
    .dp_i          (dp_i),
    .load_valid_i  (load_valid_i),
    .load_ready_o  (load_ready_o),
    .lz_suppress_i (lz_suppress_i),
    .seg_o         (seg_o),
    .dp_o          (dp_o),
    .an_o          (an_o),
    .frame_o       (frame_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [N-1:0] dpm);
    logic [6:0] segs [N];
    exp_t e;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int k = 0; k < N; k++) begin
      e.an  = ~(N'(1) << k);
      e.seg = segs[k];
      e.dp  = ~dpm[k];
      exp_q.push_back(e);
    end
  endtask

  // Returns at the negedge where frame_o is high.
  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_o && n < 40);
    if (!frame_o) chk("frame_timeout", 0, 1);
  endtask

  // Starts at a negedge; returns #1 after the accepting edge.
  task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] d,
                         output int waited, output logic fr_at_ready);
    value_i = v;
    dp_i = d;
    load_valid_i = 1'b1;
    waited = 0;
    while (!load_ready_o && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!load_ready_o) chk("load_timeout", 0, 1);
    fr_at_ready = frame_o;
    @(posedge clk);
    #1;
    load_valid_i = 1'b0;
    chk("ready_low_after_accept", int'(load_ready_o), 0);
  endtask

  // Monitor: blank-slot checks, frame period, and scoreboard pops on slot start.
  initial begin : monitor
    logic [N-1:0] prev_an;
    int cyc, last_frame;
    exp_t e;
    prev_an = '1;
    cyc = 0;
    last_frame = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) last_frame = -1;
      else if (frame_o) begin
        if (last_frame >= 0) chk("frame_period", cyc - last_frame, 16);
        last_frame = cyc;
      end
      if (an_o == '1) begin
        chk("blank_seg", int'(seg_o), 7'h7F);
        chk("blank_dp", int'(dp_o), 1);
      end else if (prev_an == '1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("slot_an", int'(an_o), int'(e.an));
        chk("slot_seg", int'(seg_o), int'(e.seg));
        chk("slot_dp", int'(dp_o), int'(e.dp));
      end
      prev_an = an_o;
    end
  end

  initial begin : stimulus
    int   w;
    logic fr;

    repeat (3) @(negedge clk);
    chk("rst_an", int'(an_o), 4'hF);
    chk("rst_seg", int'(seg_o), 7'h7F);
    chk("rst_dp", int'(dp_o), 1);
    chk("rst_frame", int'(frame_o), 0);
    chk("rst_ready", int'(load_ready_o), 1);

    // Frame A: zeros; 12AF loaded mid-frame must not show until the wrap.
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_load(16'h12AF, 4'b0000, w, fr);
    wait_frame();

    // Frame B: 12AF; load 3456, then hold 789C while ready is low.
    push_frame(7'h0E, 7'h08, 7'h24, 7'h79, 4'b0000);
    do_load(16'h3456, 4'b0000, w, fr);
    do_load(16'h789C, 4'b0100, w, fr);
    chk("hold_waited", int'(w > 4), 1);
    chk("ready_rise_at_frame", int'(fr), 1);

    // Frame C: 3456; 789C is pending.
    push_frame(7'h02, 7'h12, 7'h19, 7'h30, 4'b0000);
    wait_frame();

    // Frame D: 789C with dp on digit 2; suppression on, load 0050.
    push_frame(7'h46, 7'h10, 7'h00, 7'h78, 4'b0100);
    lz_suppress_i = 1'b1;
    do_load(16'h0050, 4'b0000, w, fr);
    wait_frame();

    // Frame E: 0050 suppressed; load 0000.
    push_frame(7'h40, 7'h12, 7'h7F, 7'h7F, 4'b0000);
    do_load(16'h0000, 4'b0000, w, fr);
    wait_frame();

    // Frame F: all zero, only digit 0 lit.
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000);
    wait_frame();

    // Frame G: leave a load pending, then reset mid-slot.
    do_load(16'hBEEF, 4'b1111, w, fr);
    @(negedge clk);
    chk("pending_before_rst", int'(load_ready_o), 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", int'(an_o), 4'hF);
    chk("async_rst_seg", int'(seg_o), 7'h7F);
    chk("async_rst_dp", int'(dp_o), 1);
    chk("async_rst_frame", int'(frame_o), 0);
    chk("async_rst_ready", int'(load_ready_o), 1);
    lz_suppress_i = 1'b0;
    repeat (2) @(negedge clk);

    // Two frames of zeros: display cleared and BEEF discarded.
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
    rst_n = 1'b1;
    wait_frame();
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
    chk("post_rst_ready", int'(load_ready_o), 1);
    wait_frame();

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
